opcode_dispatch: RTL and testbench

OPCODE_DISPATCH -- requirements
Module: opcode_dispatch

---
 rtl/opcode_dispatch_pkg.sv | 33 +++
 rtl/opcode_classifier.sv | 25 ++
 rtl/opcode_dispatch.sv | 112 +++++++++++
 tb/tb_opcode_dispatch.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/opcode_dispatch_pkg.sv
// Shared types and constants for the opcode dispatcher.
//   cmd_class_e : 3-bit command class code driven on o_out_class
//   disp_state_e: dispatcher FSM states
//   OPC_*       : opcode range boundaries used by the classifier
package opcode_dispatch_pkg;

  typedef enum logic [2:0] {
    CLS_0   = 3'd0,
    CLS_1   = 3'd1,
    CLS_2   = 3'd2,   // carries operand bytes
    CLS_3   = 3'd3,
    CLS_4   = 3'd4,
    CLS_5   = 3'd5,   // carries operand bytes
    CLS_ILL = 3'd7
  } cmd_class_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPERAND = 2'd1,
    ST_ISSUE   = 2'd2
  } disp_state_e;

  localparam logic [7:0] OPC_CLS0    = 8'd0;
  localparam logic [7:0] OPC_CLS1    = 8'd1;
  localparam logic [7:0] OPC_CLS2    = 8'd2;
  localparam logic [7:0] OPC_CLS3_LO = 8'd3;
  localparam logic [7:0] OPC_CLS3_HI = 8'd4;
  localparam logic [7:0] OPC_CLS4_LO = 8'd5;
  localparam logic [7:0] OPC_CLS4_HI = 8'd7;
  localparam logic [7:0] OPC_CLS5_LO = 8'd10;
  localparam logic [7:0] OPC_CLS5_HI = 8'd17;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode classifier.
//   opcode      : raw 8-bit opcode
//   op_class    : class code (CLS_ILL for anything outside the known ranges)
//   has_operand : class is followed by operand bytes
module opcode_classifier
  import opcode_dispatch_pkg::*;
(
  input  logic [7:0]  opcode,
  output cmd_class_e  op_class,
  output logic        has_operand
);

  always_comb begin
    op_class = CLS_ILL;
    if (opcode == OPC_CLS0)                                    op_class = CLS_0;
    else if (opcode == OPC_CLS1)                               op_class = CLS_1;
    else if (opcode == OPC_CLS2)                               op_class = CLS_2;
    else if (opcode >= OPC_CLS3_LO && opcode <= OPC_CLS3_HI)   op_class = CLS_3;
    else if (opcode >= OPC_CLS4_LO && opcode <= OPC_CLS4_HI)   op_class = CLS_4;
    else if (opcode >= OPC_CLS5_LO && opcode <= OPC_CLS5_HI)   op_class = CLS_5;
  end

  assign has_operand = (op_class == CLS_2) || (op_class == CLS_5);

endmodule

// File: rtl/opcode_dispatch.sv
// Byte-stream opcode dispatcher. Collects an opcode plus, for operand-carrying
// classes, OPERAND_BYTES little-endian operand bytes, then presents the command
// on a valid/ready interface. Illegal opcodes are dropped and counted.
//   i_clk/i_rst        : clock, synchronous active-high reset
//   i_in_valid/o_in_ready/i_in_data : input byte stream
//   o_out_valid/i_out_ready         : command handshake
//   o_out_class/o_out_opcode/o_out_operand : command payload
//   o_err_count        : saturating illegal-opcode count
//   o_busy             : FSM not idle
module opcode_dispatch
  import opcode_dispatch_pkg::*;
#(
  parameter int OPERAND_BYTES = 2,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [7:0]                 i_in_data,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [2:0]                 o_out_class,
  output logic [7:0]                 o_out_opcode,
  output logic [8*OPERAND_BYTES-1:0] o_out_operand,
  output logic [ERR_CNT_W-1:0]       o_err_count,
  output logic                       o_busy
);

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OPERAND_BYTES - 1);

  disp_state_e                state_q, state_d;
  logic [CNT_W-1:0]           byte_cnt_q;
  cmd_class_e                 cls_q;
  logic [7:0]                 opcode_q;
  logic [8*OPERAND_BYTES-1:0] operand_q;
  logic [ERR_CNT_W-1:0]       err_q;

  cmd_class_e in_cls;
  logic       in_has_opnd;
  logic       in_fire;

  opcode_classifier u_cls (
    .opcode      (i_in_data),
    .op_class    (in_cls),
    .has_operand (in_has_opnd)
  );

  // Outputs decode from registered state only, so no input reaches an output
  // combinationally.
  assign o_in_ready  = (state_q != ST_ISSUE);
  assign o_out_valid = (state_q == ST_ISSUE);
  assign o_busy      = (state_q != ST_IDLE);
  assign in_fire     = i_in_valid && o_in_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_fire && in_cls != CLS_ILL)
          state_d = in_has_opnd ? ST_OPERAND : ST_ISSUE;
      end
      ST_OPERAND: begin
        if (in_fire && byte_cnt_q == LAST_IDX) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (i_out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Payload registers only load while collecting, so they hold steady for the
  // whole time the command sits in ISSUE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      byte_cnt_q <= '0;
      cls_q      <= CLS_0;
      opcode_q   <= '0;
      operand_q  <= '0;
      err_q      <= '0;
    end else begin
      if (state_q == ST_IDLE && in_fire) begin
        if (in_cls == CLS_ILL) begin
          if (err_q != {ERR_CNT_W{1'b1}}) err_q <= err_q + 1'b1;
        end else begin
          cls_q      <= in_cls;
          opcode_q   <= i_in_data;
          operand_q  <= '0;   // no-operand classes present zero
          byte_cnt_q <= '0;
        end
      end
      if (state_q == ST_OPERAND && in_fire) begin
        for (int b = 0; b < OPERAND_BYTES; b++)
          if (byte_cnt_q == CNT_W'(b)) operand_q[b*8 +: 8] <= i_in_data;
        byte_cnt_q <= byte_cnt_q + 1'b1;
      end
    end
  end

  assign o_out_class   = cls_q;
  assign o_out_opcode  = opcode_q;
  assign o_out_operand = operand_q;
  assign o_err_count   = err_q;

endmodule

// File: tb/tb_opcode_dispatch.sv
// Self-checking bench for opcode_dispatch: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level model (byte queue + pending command).
module tb_opcode_dispatch;

  localparam int OB = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;

  logic            in_ready, out_valid, busy;
  logic [2:0]      out_class;
  logic [7:0]      out_opcode;
  logic [8*OB-1:0] out_operand;
  logic [7:0]      err_count;

  // Second instance with a tiny error counter to exercise saturation.
  logic            d2_in_ready, d2_out_valid, d2_busy;
  logic [2:0]      d2_out_class;
  logic [7:0]      d2_out_opcode;
  logic [8*OB-1:0] d2_out_operand;
  logic [1:0]      d2_err_count;

  opcode_dispatch #(.OPERAND_BYTES(OB), .ERR_CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_class(out_class), .o_out_opcode(out_opcode), .o_out_operand(out_operand),
    .o_err_count(err_count), .o_busy(busy)
  );

  opcode_dispatch #(.OPERAND_BYTES(OB), .ERR_CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(d2_in_ready),
    .i_in_data(in_data), .o_out_valid(d2_out_valid), .i_out_ready(out_ready),
    .o_out_class(d2_out_class), .o_out_opcode(d2_out_opcode), .o_out_operand(d2_out_operand),
    .o_err_count(d2_err_count), .o_busy(d2_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] ref_class(input logic [7:0] b);
    if (b == 8'd0) return 3'd0;
    if (b == 8'd1) return 3'd1;
    if (b == 8'd2) return 3'd2;
    if (b >= 8'd3  && b <= 8'd4)  return 3'd3;
    if (b >= 8'd5  && b <= 8'd7)  return 3'd4;
    if (b >= 8'd10 && b <= 8'd17) return 3'd5;
    return 3'd7;
  endfunction

  function automatic int ref_nops(input logic [2:0] c);
    return (c == 3'd2 || c == 3'd5) ? OB : 0;
  endfunction

  bit              m_pend;
  logic [7:0]      m_opc;
  logic [2:0]      m_cls;
  logic [8*OB-1:0] m_opnd;
  logic [7:0]      m_q[$];
  int              m_err, m_err2;

  always @(posedge clk) begin : mdl
    bit              fire_in;
    logic [2:0]      c;
    logic [8*OB-1:0] acc;
    if (rst) begin
      m_pend = 1'b0;
      m_q.delete();
      m_err  = 0;
      m_err2 = 0;
    end else begin
      fire_in = in_valid && !m_pend;
      if (m_pend && out_ready) m_pend = 1'b0;
      if (fire_in) begin
        if (m_q.size() == 0) begin
          c = ref_class(in_data);
          if (c == 3'd7) begin
            if (m_err < 255) m_err++;
            if (m_err2 < 3) m_err2++;
          end else if (ref_nops(c) == 0) begin
            m_pend = 1'b1; m_opc = in_data; m_cls = c; m_opnd = '0;
          end else begin
            m_q.push_back(in_data);
          end
        end else begin
          m_q.push_back(in_data);
          if (m_q.size() == 1 + OB) begin
            acc = '0;
            for (int i = 1; i <= OB; i++) acc[8*(i-1) +: 8] = m_q[i];
            m_pend = 1'b1; m_opc = m_q[0]; m_cls = ref_class(m_q[0]); m_opnd = acc;
            m_q.delete();
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  32'(in_ready),  32'(!m_pend));
      chk("out_valid", 32'(out_valid), 32'(m_pend));
      chk("busy",      32'(busy),      32'(m_pend || m_q.size() > 0));
      chk("err_count", 32'(err_count), 32'(m_err));
      chk("err_count_w2", 32'(d2_err_count), 32'(m_err2));
      if (m_pend) begin
        chk("out_class",   32'(out_class),   32'(m_cls));
        chk("out_opcode",  32'(out_opcode),  32'(m_opc));
        chk("out_operand", 32'(out_operand), 32'(m_opnd));
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    drive(1'b1, 8'h0C, 1'b0);
    drive(1'b1, 8'h0C, 1'b0);
    chk("rst_valid",   32'(out_valid),   32'd0);
    chk("rst_ready",   32'(in_ready),    32'd1);
    chk("rst_class",   32'(out_class),   32'd0);
    chk("rst_opcode",  32'(out_opcode),  32'd0);
    chk("rst_operand", 32'(out_operand), 32'd0);
    chk("rst_err",     32'(err_count),   32'd0);
    chk("rst_busy",    32'(busy),        32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // no-operand opcode, latency 1, back to idle next cycle
    drive(1'b1, 8'h03, 1'b1);
    chk("op03_valid",   32'(out_valid),   32'd1);
    chk("op03_class",   32'(out_class),   32'd3);
    chk("op03_operand", 32'(out_operand), 32'd0);
    chk("op03_ready",   32'(in_ready),    32'd0);
    drive(1'b0, 8'h00, 1'b1);
    chk("op03_idle", 32'(busy), 32'd0);

    // operand command, little-endian
    drive(1'b1, 8'h02, 1'b1);
    drive(1'b1, 8'h34, 1'b1);
    chk("op02_mid_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 8'h12, 1'b1);
    chk("op02_class",   32'(out_class),   32'd2);
    chk("op02_operand", 32'(out_operand), 32'h1234);
    chk("op02_opcode",  32'(out_opcode),  32'h02);
    drive(1'b0, 8'h00, 1'b1);

    // illegal opcodes and saturation
    drive(1'b1, 8'h08, 1'b0);
    drive(1'b1, 8'hFF, 1'b0);
    chk("ill_valid", 32'(out_valid), 32'd0);
    chk("ill_err2",  32'(err_count), 32'd2);
    drive(1'b1, 8'h09, 1'b0);
    drive(1'b1, 8'h20, 1'b0);
    drive(1'b1, 8'h80, 1'b0);
    chk("ill_err5",     32'(err_count),    32'd5);
    chk("ill_sat_w2",   32'(d2_err_count), 32'd3);

    // back-pressure: payload held, input stalled
    drive(1'b1, 8'h0C, 1'b0);
    drive(1'b1, 8'hAA, 1'b0);
    drive(1'b1, 8'hBB, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid",   32'(out_valid),   32'd1);
      chk("bp_class",   32'(out_class),   32'd5);
      chk("bp_operand", 32'(out_operand), 32'hBBAA);
      chk("bp_ready",   32'(in_ready),    32'd0);
      drive(1'b1, 8'h55, 1'b0);
    end
    drive(1'b0, 8'h00, 1'b1);
    chk("bp_done", 32'(out_valid), 32'd0);
    chk("bp_err",  32'(err_count), 32'd5);

    // reset discards partial command
    drive(1'b1, 8'h02, 1'b0);
    drive(1'b1, 8'h11, 1'b0);
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_busy",  32'(busy),      32'd0);
    drive(1'b1, 8'h01, 1'b1);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_class", 32'(out_class), 32'd1);
    drive(1'b0, 8'h00, 1'b1);

    // input gaps while collecting operands
    drive(1'b1, 8'h0A, 1'b1);
    drive(1'b0, 8'h99, 1'b1);
    drive(1'b1, 8'h78, 1'b1);
    drive(1'b0, 8'h99, 1'b1);
    chk("gap_busy", 32'(busy), 32'd1);
    drive(1'b1, 8'h56, 1'b1);
    chk("gap_class",   32'(out_class),   32'd5);
    chk("gap_operand", 32'(out_operand), 32'h5678);
    drive(1'b0, 8'h00, 1'b1);

    // randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] d;
      rst = ($urandom_range(0, 199) == 0);
      d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 17)) : 8'($urandom);
      drive(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0));
    end
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
